// File: rtl/timer_pkg.sv
// Shared encodings for the multi-channel down-counting timer.
package timer_pkg;

    typedef enum logic {
        TMR_IDLE = 1'b0,
        TMR_RUN  = 1'b1
    } tmr_state_e;

    localparam logic TMR_ONESHOT = 1'b0;
    localparam logic TMR_RELOAD  = 1'b1;

endpackage

// File: rtl/timer_channel.sv
// One down-counting timer channel: start/stop control, one-shot or auto-reload,
// registered one-cycle expiry pulse.
module timer_channel
    import timer_pkg::*;
#(
    parameter int WIDTH = 9
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             tick,
    input  logic             start,
    input  logic             stop,
    input  logic             auto_reload,
    input  logic [WIDTH-1:0] load_value,
    output logic             out,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    tmr_state_e       state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic             mode_q, mode_d;
    logic             out_q, out_d;

    always_comb begin
        // NOTE: every variable gets a hold/default value first so no path leaves it unassigned (no latch).
        state_d  = state_q;
        count_d  = count_q;
        reload_d = reload_q;
        mode_d   = mode_q;
        out_d    = 1'b0;

        if (start) begin
            count_d  = load_value;
            reload_d = load_value;
            mode_d   = auto_reload;
            state_d  = TMR_RUN;
        end else if (stop) begin
            state_d = TMR_IDLE;
        end else if (state_q == TMR_RUN && tick) begin
            // Zero is tested before decrementing, so the count never wraps.
            if (count_q != '0) begin
                count_d = count_q - 1'b1;
            end else begin
                out_d = 1'b1;
                if (mode_q == TMR_RELOAD) begin
                    count_d = reload_q;
                end else begin
                    state_d = TMR_IDLE;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q  <= TMR_IDLE;
            count_q  <= '0;
            reload_q <= '0;
            mode_q   <= TMR_ONESHOT;
            out_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            reload_q <= reload_d;
            mode_q   <= mode_d;
            out_q    <= out_d;
        end
    end

    assign out   = out_q;
    assign busy  = (state_q == TMR_RUN);
    assign count = count_q;

endmodule

// File: rtl/multi_timer.sv
// CHANNELS independent down-counting timers sharing one tick.
// Define TIMER_PRESCALER_EN to divide count_en by PRESCALE before it reaches the channels.
module multi_timer
    import timer_pkg::*;
#(
    parameter int WIDTH    = 9,
    parameter int CHANNELS = 4,
    parameter int PRESCALE = 4
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      count_en,
    input  logic [CHANNELS-1:0]       start,
    input  logic [CHANNELS-1:0]       stop,
    input  logic [CHANNELS-1:0]       auto_reload,
    input  logic [CHANNELS*WIDTH-1:0] load_value,
    output logic [CHANNELS-1:0]       out,
    output logic [CHANNELS-1:0]       busy,
    output logic [CHANNELS*WIDTH-1:0] count
);

    if (PRESCALE < 1) begin : g_bad_prescale
        $error("multi_timer: PRESCALE must be at least 1");
    end

    logic tick;

`ifdef TIMER_PRESCALER_EN
    localparam int                PRE_W    = $clog2(PRESCALE) + 1;
    localparam logic [PRE_W-1:0]  PRE_LAST = PRE_W'(PRESCALE - 1);

    logic [PRE_W-1:0] pre_q, pre_d;

    // Free-running: start/stop never touch the prescaler.
    always_comb begin
        pre_d = pre_q;
        if (count_en) begin
            pre_d = (pre_q == PRE_LAST) ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

    assign tick = count_en && (pre_q == PRE_LAST);
`else
    assign tick = count_en;
`endif

    for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
        timer_channel #(
            .WIDTH(WIDTH)
        ) u_ch (
            .clock      (clock),
            .reset      (reset),
            .tick       (tick),
            .start      (start[c]),
            .stop       (stop[c]),
            .auto_reload(auto_reload[c]),
            .load_value (load_value[c*WIDTH +: WIDTH]),
            .out        (out[c]),
            .busy       (busy[c]),
            .count      (count[c*WIDTH +: WIDTH])
        );
    end

endmodule

// File: tb/tb_multi_timer.sv
// Directed bench for multi_timer; observes state 1 time unit after each rising edge.
module tb_multi_timer;

    localparam int W  = 9;
    localparam int CH = 4;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic              count_en = 1'b0;
    logic [CH-1:0]     start = '0;
    logic [CH-1:0]     stop = '0;
    logic [CH-1:0]     auto_reload = '0;
    logic [CH*W-1:0]   load_value = '0;
    logic [CH-1:0]     out;
    logic [CH-1:0]     busy;
    logic [CH*W-1:0]   count;

    int errors = 0;
    int checks = 0;

    multi_timer #(.WIDTH(W), .CHANNELS(CH), .PRESCALE(4)) dut (
        .clock      (clock),
        .reset      (reset),
        .count_en   (count_en),
        .start      (start),
        .stop       (stop),
        .auto_reload(auto_reload),
        .load_value (load_value),
        .out        (out),
        .busy       (busy),
        .count      (count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    function automatic logic [W-1:0] cnt(input int c);
        return count[c*W +: W];
    endfunction

    // Strobe start for one edge; on return we observe the cycle right after the start edge.
    task automatic arm(input int c, input int l, input logic ar);
        start[c]              = 1'b1;
        auto_reload[c]        = ar;
        load_value[c*W +: W]  = W'(l);
        cyc();
        start[c] = 1'b0;
    endtask

    task automatic idle_all();
        stop = '1;
        cyc();
        stop = '0;
    endtask

    // i counts edges since the start edge; period is l+1 ticks with count_en high.
    task automatic watch_periodic(input int c, input int l, input int i0, input int n);
        for (int i = i0; i < i0 + n; i++) begin
            check($sformatf("ar_out c%0d L%0d i%0d", c, l, i), 64'(out[c]),
                  64'((i > 0) && (i % (l + 1) == 0)));
            check($sformatf("ar_cnt c%0d L%0d i%0d", c, l, i), 64'(cnt(c)),
                  64'(l - (i % (l + 1))));
            cyc();
        end
    endtask

    initial begin
        int per;
        logic [CH-1:0] exp_v;

        cyc();
        cyc();
        check("rst_out", 64'(out), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_count", 64'(count), 64'(0));
        reset = 1'b1;
        cyc();

        // Prescale: L=1 auto-reload, count_en rises right after the start edge.
`ifdef TIMER_PRESCALER_EN
        per = 8;
`else
        per = 2;
`endif
        arm(0, 1, 1'b1);
        count_en = 1'b1;
        for (int i = 0; i < 25; i++) begin
            check($sformatf("pre_out i%0d", i), 64'(out[0]), 64'((i > 0) && (i % per == 0)));
            cyc();
        end
        idle_all();

`ifndef TIMER_PRESCALER_EN
        // One-shot L=3: pulse 4 edges after start edge, busy drops with it.
        arm(0, 3, 1'b0);
        for (int i = 0; i < 7; i++) begin
            check($sformatf("os_out i%0d", i), 64'(out[0]), 64'(i == 4));
            check($sformatf("os_busy i%0d", i), 64'(busy[0]), 64'(i < 4));
            check($sformatf("os_cnt i%0d", i), 64'(cnt(0)), 64'((i < 3) ? 3 - i : 0));
            cyc();
        end

        // No tick: RUN holds its count.
        count_en = 1'b0;
        arm(2, 3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("hold_cnt i%0d", i), 64'(cnt(2)), 64'(3));
            check($sformatf("hold_busy i%0d", i), 64'(busy[2]), 64'(1));
            cyc();
        end
        count_en = 1'b1;
        idle_all();

        // Auto-reload L=2 for 10 periods; load_value change mid-run is ignored.
        arm(1, 2, 1'b1);
        watch_periodic(1, 2, 0, 15);
        load_value[1*W +: W] = W'(7);
        watch_periodic(1, 2, 15, 15);
        arm(1, 7, 1'b1);
        watch_periodic(1, 7, 0, 17);
        idle_all();

        // L=0 auto-reload pulses on every tick.
        arm(2, 0, 1'b1);
        for (int i = 0; i < 6; i++) begin
            check($sformatf("l0_out i%0d", i), 64'(out[2]), 64'(i > 0));
            cyc();
        end
        idle_all();

        // Start and stop together: start wins.
        start[3] = 1'b1;
        stop[3]  = 1'b1;
        load_value[3*W +: W] = W'(4);
        cyc();
        start[3] = 1'b0;
        stop[3]  = 1'b0;
        check("ss_busy", 64'(busy[3]), 64'(1));
        check("ss_cnt", 64'(cnt(3)), 64'(4));
        idle_all();

        // Stop on the expiry edge suppresses the pulse.
        arm(3, 1, 1'b0);
        check("se_cnt0", 64'(cnt(3)), 64'(1));
        cyc();
        check("se_cnt1", 64'(cnt(3)), 64'(0));
        check("se_out1", 64'(out[3]), 64'(0));
        stop[3] = 1'b1;
        cyc();
        stop[3] = 1'b0;
        check("se_out2", 64'(out[3]), 64'(0));
        check("se_busy2", 64'(busy[3]), 64'(0));
        check("se_cnt2", 64'(cnt(3)), 64'(0));
        cyc();
        check("se_out3", 64'(out[3]), 64'(0));

        // Independence: L=0..3 together; all coincide every 12 edges.
        for (int c = 0; c < CH; c++) begin
            load_value[c*W +: W] = W'(c);
        end
        auto_reload = '1;
        start = '1;
        cyc();
        start = '0;
        for (int i = 0; i < 25; i++) begin
            for (int c = 0; c < CH; c++) begin
                exp_v[c] = (i > 0) && (i % (c + 1) == 0);
            end
            check($sformatf("ind_out i%0d", i), 64'(out), 64'(exp_v));
            cyc();
        end
        idle_all();
`endif

        // Reset mid-run: aborts immediately, no later pulse.
        arm(0, 5, 1'b0);
        cyc();
        cyc();
        #2;
        reset = 1'b0;
        #1;
        check("mr_out", 64'(out), 64'(0));
        check("mr_busy", 64'(busy), 64'(0));
        check("mr_count", 64'(count), 64'(0));
        @(negedge clock);
        reset = 1'b1;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check($sformatf("mr_post_out i%0d", i), 64'(out), 64'(0));
            check($sformatf("mr_post_busy i%0d", i), 64'(busy), 64'(0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/multi_timer.md
# multi_timer

Parametrised multi-channel down-counting timer, successor to the single 9-bit `timer`. It provides CHANNELS independent counters of WIDTH bits. Each counter has its own start/stop control, a one-shot or auto-reload mode, and a one-cycle expiry pulse. All channels advance on a shared `count_en` tick. The block sits beside the control FSMs and drives periodic events such as sample strobes, beat ticks and timeouts.

## Interface
- WIDTH, 9: counter width in bits.
- CHANNELS, 4: number of independent channels.
- PRESCALE, 4: `count_en` pulses per internal tick. Used only with TIMER_PRESCALER_EN; must be ≥1.

- clock  input  1: single clock, rising edge.
- reset  input  1: asynchronous, active-low reset.
- count_en  input  1: global tick enable.
- start  input  CHANNELS: per-channel start or restart strobe.
- stop  input  CHANNELS: per-channel stop strobe.
- auto_reload  input  CHANNELS: per-channel mode, sampled on start. 1 = periodic, 0 = one-shot.
- load_value  input  CHANNELS*WIDTH: per-channel load value. Channel c uses bits [c*WIDTH +: WIDTH].
- out  output  CHANNELS: one-cycle expiry pulse, registered.
- busy  output  CHANNELS: channel is in RUN.
- count  output  CHANNELS*WIDTH: current counter values.

## Operation
- Each channel has two states: IDLE (0) and RUN (1).
- Each channel holds registered state, count, reload and mode.
- **start[c] (any state):**
  - count ← load_value[c]; reload ← load_value[c]; mode ← auto_reload[c]; state ← RUN.
  - A tick in the start cycle is ignored for that channel.
- **stop[c] without start[c]:** state ← IDLE; count holds. If start and stop are both asserted, start wins.
- **RUN with tick:**
  - If count ≠ 0: count ← count−1.
  - If count = 0: out[c] ← 1 for the next cycle.
    - mode = 1: count ← reload; stay in RUN.
    - mode = 0: state ← IDLE; count stays 0.
- **RUN without tick:** all registers hold.
- **IDLE:** ticks are ignored and out stays 0.
- load_value changes while in RUN have no effect until the next start.
- Arithmetic is unsigned modulo 2^WIDTH. The decrement never underflows because zero is detected first.
- load_value = 0:
  - One-shot: expires on the first tick after start.
  - Auto-reload: pulses on every tick.
- Channels are fully independent. Simultaneous expiries on several channels all pulse in the same cycle.

## Timing
- Reset (reset = 0, asynchronous): state = IDLE, count = 0, reload = 0, mode = 0, out = 0, busy = 0, prescaler = 0. Reset mid-run aborts the channel immediately, with no pulse.
- start sampled at edge k: busy = 1 and count = L from cycle k+1.
- With count_en held high, out pulses in cycle k+L+2, i.e. L+1 ticks after start.
- Auto-reload period: L+1 ticks between successive pulses.
- out is exactly one cycle wide. It cannot be asserted two cycles in a row unless L = 0 with auto-reload and the tick is held high.
- A one-shot channel drops busy in the same cycle its out pulse is asserted.
- stop on the same edge as an expiring tick: stop wins and no pulse is produced.

## Configuration
- TIMER_PRESCALER_EN defined:
  - A shared counter of width $clog2(PRESCALE)+1 counts count_en pulses.
  - The internal tick = count_en AND (prescaler = PRESCALE−1); the prescaler then wraps to 0.
  - The prescaler free-runs and is unaffected by start and stop.
- TIMER_PRESCALER_EN undefined: tick = count_en directly, PRESCALE is ignored, and no prescaler register exists.

## Structure
- Package timer_pkg:
  - State encoding: TMR_IDLE = 1'b0, TMR_RUN = 1'b1.
  - Mode constants: TMR_ONESHOT = 1'b0, TMR_RELOAD = 1'b1.
- Sub-module timer_channel (parameter WIDTH):
  - Inputs: clock, reset, tick, start, stop, auto_reload, load_value.
  - Outputs: out, busy, count.
- The top level contains the optional prescaler and a generate loop over CHANNELS.

## Test plan
- Reset mid-run: ch0 started with L = 5, reset low at tick 2 → out = 0, busy = 0 and count = 0 immediately; no later pulse.
- One-shot, L = 3, count_en held high, start at edge k → out[0] high only in cycle k+5; busy low from k+5; count stays 0.
- Auto-reload, L = 2, count_en high → pulses every 3 cycles for 10 periods. Changing load_value to 7 mid-run keeps the period at 3 until restart, after which the period is 8.
- Edge cases: L = 0 auto-reload gives out high on every tick. Start and stop asserted together gives busy = 1. Stop on the expiry edge gives no pulse.
- Independence: CHANNELS = 4 with L = 0, 1, 2, 3 started together → all four pulse together every 12 cycles, with individual periods 1, 2, 3, 4.
- With TIMER_PRESCALER_EN, PRESCALE = 4, L = 1, count_en high → out pulses every 8 cycles. Without the macro the same stimulus pulses every 2 cycles.
